row_packer: RTL and testbench
=============================

// Module: row_packer
// PURPOSE
//  Capture-side counterpart of the display row buffer: accepts 16-bit pixels one at a time and packs
//  8 pixels into each 128-bit word. Stores words in a two-bank (ping-pong) row store and hands each
//  completed row to the SDRAM write port as an 80-word burst. Sits between camera pixel formatting
//  and the SDRAM controller, all in the SDRAM clock domain.
// PARAMETERS
//  PIX_W          16   pixel width
//  WORD_W         128  SDRAM word width (= 8*PIX_W)
//  WORDS_PER_ROW  80   words per row (640 px)
//  ROWS           480  rows per frame; row index wraps ROWS-1 -> 0
// PORTS
//  clk          in   1    system/SDRAM clock
//  rst_n        in   1    synchronous reset, active low
//  frame_start  in   1    1-cycle pulse: restart packing at row 0, pixel 0
//  pix_valid    in   1    pix_data valid this cycle
//  pix_data     in   16   pixel, row-major, left to right
//  wr_req       out  1    a full bank is ready for write-out
//  wr_row       out  9    row index of the bank being offered/drained
//  wr_ack       in   1    controller accepts request; burst starts next cycle
//  wr_data_en   in   1    controller pulls one word this cycle
//  wr_data      out  128  word, valid the cycle after wr_data_en
//  row_done     out  1    1-cycle pulse when the last word of a burst has been presented
//  overflow     out  1    sticky: a row was dropped because both banks were full
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all outputs 0; both banks empty; pack/drain counters, row tags and
//   bank pointers at 0; drain FSM in IDLE.
//  Packing:
//   - Pixel k of a word goes to bits [16k+15:16k], so pixel 0 is in [15:0].
//   - The 3-bit lane counter advances only on pix_valid. On lane 7 the assembled word is written
//     to bank[wbank][word_cnt].
//   - After word 79 is written: bank wbank is marked full and tagged with the current row; wbank
//     toggles; row increments, wrapping at ROWS-1.
//  Overflow:
//   - Decided when a row starts: if bank wbank is still full, the whole row is discarded.
//   - Pixels are counted but not written, overflow is set, and the row counter still advances.
//   - Packing re-checks at the next row start.
//  frame_start:
//   - Clears lane/word/row counters and overflow. Any partial row is discarded.
//   - A drain in progress completes normally. Full banks are kept.
//   - If frame_start and pix_valid occur together, the pixel is the first pixel of the new frame.
//  Drain FSM:
//   - IDLE: when bank rbank is full -> REQ. wr_req=1 and wr_row=tag[rbank] are registered and
//     held stable until ack.
//   - REQ: on wr_ack -> BURST. wr_req drops the next cycle.
//   - BURST: each wr_data_en reads bank[rbank][rd_cnt]; wr_data is registered (1-cycle latency);
//     rd_cnt++. wr_data holds its value when wr_data_en=0. wr_data_en outside BURST is ignored.
//   - After the 80th word is presented, row_done pulses with that word. Bank rbank is freed,
//     rbank toggles, and the FSM goes to IDLE. The same cycle may re-enter REQ if the other bank
//     is full.
//  Simultaneous events:
//   - A bank freed in the same cycle a new row starts into it counts as empty: no overflow.
//   - Fill and drain of different banks proceed concurrently.
//   - Each bank has one writer and one reader. Bank-full flags are set by the packer, cleared by
//     the drain FSM, and a set/clear collision is impossible by construction.
//  Widths: word_cnt and rd_cnt are 7 bits (0..79); row is 9 bits. No arithmetic beyond counters.
// STRUCTURE
//  - Shared package/header: PIX_W, WORD_W, WORDS_PER_ROW, ROWS, drain FSM state encodings
//    (IDLE, REQ, BURST).
//  - One sub-module, row_bank_ram: 2x80x128 simple dual-port RAM with a 1-bit bank select
//    appended to the address. One write port, one registered read port, single clock, so it infers
//    block RAM.
//  - The top level holds the packer, the drain FSM, the bank flags and the row tags.
// TESTING
//  1. Reset, then 640 valid pixels with value = index -> wr_req=1, wr_row=0; ack + 80 wr_data_en
//     -> word0=0x0007_0006_..._0000, word79 lanes 0x278..0x27F; row_done on word 79.
//  2. Pixels with random pix_valid gaps across 2 rows, controller never acks -> both banks full;
//     a 3rd row -> overflow=1, no bank data changed. Then drain both -> wr_row 0 then 1 only.
//  3. Row 2 starts in the same cycle bank 0 is freed -> overflow stays 0; row 2 data correct.
//  4. Drain with wr_data_en toggling 1/0 -> each word appears once, 1 cycle after its enable,
//     held during gaps.
//  5. frame_start after 300 pixels of row 5, mid-drain of row 4 -> the row 4 burst completes;
//     the next request has wr_row=0; overflow cleared.
//  6. Run 481 rows with immediate drains -> wr_row sequence 0..479 then 0; rst_n=0 mid-burst ->
//     all outputs 0 next cycle.

Source files
------------

// File: rtl/row_packer_pkg.sv
// ----------------------------------------------------------------------------
// row_packer_pkg
// Shared constants and types for the capture-side row packer.
//   PIX_W          pixel width
//   WORD_W         SDRAM word width (8 pixels per word)
//   WORDS_PER_ROW  words per 640-pixel row
//   ROWS           rows per frame (default; the top exposes it as N_ROWS)
//   drain_state_e  write-out FSM states
// ----------------------------------------------------------------------------
package row_packer_pkg;
    localparam int PIX_W         = 16;
    localparam int WORD_W        = 128;
    localparam int WORDS_PER_ROW = 80;
    localparam int ROWS          = 480;
    localparam int LANES         = WORD_W / PIX_W;

    localparam int LANE_W = 3;
    localparam int WCNT_W = 7;
    localparam int ROW_W  = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BURST = 2'd2
    } drain_state_e;
endpackage

// File: rtl/row_packer_bank_ram.sv
// ----------------------------------------------------------------------------
// row_bank_ram
// Two-bank row store, 2 x 80 words x 128 bits, simple dual port, one clock.
// The bank select is the top address bit on both ports.
//   clk      clock
//   rst_n    synchronous active-low reset (read register only)
//   i_we     write enable
//   i_wbank  write bank select
//   i_waddr  write word address within the bank
//   i_wdata  write data
//   i_re     read enable; o_rdata updates the cycle after
//   i_rbank  read bank select
//   i_raddr  read word address within the bank
//   o_rdata  registered read data, holds while i_re is low
// ----------------------------------------------------------------------------
module row_bank_ram
    import row_packer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic              i_wbank,
    input  logic [WCNT_W-1:0] i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic              i_rbank,
    input  logic [WCNT_W-1:0] i_raddr,
    output logic [WORD_W-1:0] o_rdata
);
    logic [WORD_W-1:0] r_mem [2][WORDS_PER_ROW];
    logic [WORD_W-1:0] r_rdata;

    // NOTE: the storage array has no reset so it maps onto block RAM;
    // every word is written before it is read out.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wbank][i_waddr] <= i_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_rbank][i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/row_packer.sv
// ----------------------------------------------------------------------------
// row_packer
// Packs 16-bit pixels, eight per 128-bit word, into a ping-pong row store and
// offers each completed row to the SDRAM write port as an 80-word burst.
//   clk          clock (SDRAM domain)
//   rst_n        synchronous reset, active low
//   frame_start  restart packing at row 0, pixel 0
//   pix_valid    pix_data valid this cycle
//   pix_data     pixel, row-major, left to right
//   wr_req       a full bank is offered for write-out
//   wr_row       row index of the bank offered / being drained
//   wr_ack       controller accepts; burst starts next cycle
//   wr_data_en   controller pulls one word this cycle
//   wr_data      word, valid the cycle after wr_data_en
//   row_done     pulses with the last word of a burst
//   overflow     sticky: a row was dropped because both banks were full
// ----------------------------------------------------------------------------
module row_packer
    import row_packer_pkg::*;
#(
    parameter int N_ROWS = ROWS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              wr_req,
    output logic [ROW_W-1:0]  wr_row,
    input  logic              wr_ack,
    input  logic              wr_data_en,
    output logic [WORD_W-1:0] wr_data,
    output logic              row_done,
    output logic              overflow
);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_ROW - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(N_ROWS - 1);

    // Packer state
    logic [LANE_W-1:0]       r_lane;
    logic [WCNT_W-1:0]       r_word_cnt;
    logic [ROW_W-1:0]        r_row;
    logic                    r_wbank;
    logic                    r_drop;
    logic                    r_overflow;
    logic [WORD_W-PIX_W-1:0] r_shift;
    logic [1:0]              r_full;
    logic [ROW_W-1:0]        r_tag [2];

    // Drain state
    drain_state_e            r_state;
    drain_state_e            w_next_state;
    logic                    r_rbank;
    logic [WCNT_W-1:0]       r_rd_cnt;
    logic                    r_wr_req;
    logic [ROW_W-1:0]        r_wr_row;
    logic                    r_row_done;

    logic [LANE_W-1:0]       w_lane;
    logic [WCNT_W-1:0]       w_word;
    logic [ROW_W-1:0]        w_row;
    logic                    w_row_start;
    logic                    w_bank_busy;
    logic                    w_drop;
    logic                    w_word_done;
    logic                    w_row_end;
    logic                    w_we;
    logic                    w_set_full;
    logic                    w_rd_en;
    logic                    w_free;
    logic [WORD_W-1:0]       w_wdata;

    // ---------------------------------------------------------------- drain
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_rd_en      = 1'b0;
        w_free       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_full[r_rbank]) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (wr_ack) begin
                    w_next_state = ST_BURST;
                end
            end
            ST_BURST: begin
                if (wr_data_en) begin
                    w_rd_en = 1'b1;
                    if (r_rd_cnt == LAST_WORD) begin
                        // Last word read: release the bank and go straight
                        // back to REQ if the other bank is already waiting.
                        w_free       = 1'b1;
                        w_next_state = r_full[~r_rbank] ? ST_REQ : ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rbank    <= 1'b0;
            r_rd_cnt   <= '0;
            r_wr_req   <= 1'b0;
            r_wr_row   <= '0;
            r_row_done <= 1'b0;
        end else begin
            r_wr_req   <= (w_next_state == ST_REQ);
            r_row_done <= w_free;
            if (w_rd_en) begin
                r_rd_cnt <= w_free ? '0 : r_rd_cnt + 7'd1;
            end
            if (w_free) begin
                r_rbank <= ~r_rbank;
            end
            // Capture the tag only on entry so wr_row is stable until ack.
            if (w_next_state == ST_REQ && r_state != ST_REQ) begin
                r_wr_row <= r_tag[w_free ? ~r_rbank : r_rbank];
            end
        end
    end

    // --------------------------------------------------------------- packer
    always_comb begin
        // frame_start overrides the counters in the same cycle, so a pixel
        // arriving with it lands as pixel 0 of row 0.
        w_lane      = frame_start ? '0 : r_lane;
        w_word      = frame_start ? '0 : r_word_cnt;
        w_row       = frame_start ? '0 : r_row;
        w_row_start = pix_valid && (w_lane == '0) && (w_word == '0);
        // A bank released by the drain this very cycle counts as empty.
        w_bank_busy = r_full[r_wbank] && !(w_free && (r_rbank == r_wbank));
        w_drop      = w_row_start ? w_bank_busy : r_drop;
        w_word_done = pix_valid && (w_lane == LAST_LANE);
        w_row_end   = w_word_done && (w_word == LAST_WORD);
        w_we        = w_word_done && !w_drop;
        w_set_full  = w_row_end && !w_drop;
        w_wdata     = {pix_data, r_shift};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lane     <= '0;
            r_word_cnt <= '0;
            r_row      <= '0;
            r_wbank    <= 1'b0;
            r_drop     <= 1'b0;
            r_overflow <= 1'b0;
            r_shift    <= '0;
            r_full     <= '0;
            r_tag[0]   <= '0;
            r_tag[1]   <= '0;
        end else begin
            if (frame_start) begin
                r_lane     <= '0;
                r_word_cnt <= '0;
                r_row      <= '0;
            end
            if (pix_valid) begin
                r_lane <= w_lane + 3'd1;
                if (w_row_start) begin
                    r_drop <= w_bank_busy;
                end
                if (!w_word_done) begin
                    r_shift[32'(w_lane) * PIX_W +: PIX_W] <= pix_data;
                end else if (w_row_end) begin
                    r_word_cnt <= '0;
                    r_row      <= (w_row == LAST_ROW) ? '0 : w_row + 9'd1;
                    if (!w_drop) begin
                        r_wbank <= ~r_wbank;
                    end
                end else begin
                    r_word_cnt <= w_word + 7'd1;
                end
            end
            r_overflow <= (r_overflow && !frame_start) || (w_row_start && w_bank_busy);
            if (w_set_full) begin
                r_tag[r_wbank] <= w_row;
            end
            // Set and clear always target different banks.
            for (int b = 0; b < 2; b++) begin
                if (w_set_full && (r_wbank == b[0])) begin
                    r_full[b] <= 1'b1;
                end else if (w_free && (r_rbank == b[0])) begin
                    r_full[b] <= 1'b0;
                end
            end
        end
    end

    row_bank_ram u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_wbank (r_wbank),
        .i_waddr (w_word),
        .i_wdata (w_wdata),
        .i_re    (w_rd_en),
        .i_rbank (r_rbank),
        .i_raddr (r_rd_cnt),
        .o_rdata (wr_data)
    );

    assign wr_req   = r_wr_req;
    assign wr_row   = r_wr_row;
    assign row_done = r_row_done;
    assign overflow = r_overflow;
endmodule

// File: tb/tb_row_packer.sv
// ----------------------------------------------------------------------------
// tb_row_packer
// Directed bench for row_packer. Pixel k of row r carries (r*640 + k) mod 2^16,
// so every drained word is predictable from its row and word index. The frame
// is shortened to 8 rows so the row-index wrap is reachable in a short run.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_row_packer;
    localparam int TB_ROWS = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         frame_start = 1'b0;
    logic         pix_valid = 1'b0;
    logic [15:0]  pix_data = '0;
    logic         wr_req;
    logic [8:0]   wr_row;
    logic         wr_ack = 1'b0;
    logic         wr_data_en = 1'b0;
    logic [127:0] wr_data;
    logic         row_done;
    logic         overflow;

    int n_cmp = 0;
    int n_bad = 0;

    row_packer #(.N_ROWS(TB_ROWS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .wr_req      (wr_req),
        .wr_row      (wr_row),
        .wr_ack      (wr_ack),
        .wr_data_en  (wr_data_en),
        .wr_data     (wr_data),
        .row_done    (row_done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pix_val(input int row, input int k);
        int v;
        v = row * 640 + k;
        return v[15:0];
    endfunction

    function automatic logic [127:0] row_word(input int row, input int w);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            r[16*j +: 16] = pix_val(row, w * 8 + j);
        end
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
        wr_ack = 1'b0; wr_data_en = 1'b0; pix_data = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send_pixels(input int row, input int k0, input int n, input bit gaps);
        int g;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                pix_data = 16'hDEAD;
                repeat (g) tick();
            end
            pix_valid = 1'b1;
            pix_data  = pix_val(row, k0 + i);
            tick();
            pix_valid = 1'b0;
        end
    endtask

    task automatic req_ack(input int exp_row);
        for (int i = 0; i < 200 && wr_req !== 1'b1; i++) tick();
        n_cmp++;
        if (wr_req !== 1'b1) begin
            n_bad++;
            $display("FAIL req_timeout: wr_req=%b want 1 (row %0d)", wr_req, exp_row);
        end
        n_cmp++;
        if (wr_row !== 9'(exp_row)) begin
            n_bad++;
            $display("FAIL req_row: wr_row=%0d want %0d", wr_row, exp_row);
        end
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        n_cmp++;
        if (wr_req !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_drop: wr_req=%b want 0 (row %0d)", wr_req, exp_row);
        end
    endtask

    // Pull words first..last. With gapped=1 an idle cycle follows each
    // enable; sync_row >= 0 drives pixel 0 of that row with the final enable.
    task automatic burst_words(input int row, input int first, input int last,
                               input bit gapped, input int sync_row);
        logic [127:0] exp;
        for (int w = first; w <= last; w++) begin
            wr_data_en = 1'b1;
            if (w == last && sync_row >= 0) begin
                pix_valid = 1'b1;
                pix_data  = pix_val(sync_row, 0);
            end
            tick();
            wr_data_en = 1'b0;
            pix_valid  = 1'b0;
            exp = row_word(row, w);
            n_cmp++;
            if (wr_data !== exp) begin
                n_bad++;
                $display("FAIL word r%0d w%0d: wr_data=%h want %h", row, w, wr_data, exp);
            end
            n_cmp++;
            if (row_done !== (w == 79)) begin
                n_bad++;
                $display("FAIL row_done r%0d w%0d: got %b want %b", row, w, row_done, (w == 79));
            end
            if (gapped) begin
                tick();
                n_cmp++;
                if (wr_data !== exp || row_done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL gap_hold r%0d w%0d: wr_data=%h row_done=%b want %h / 0",
                             row, w, wr_data, row_done, exp);
                end
            end
        end
    endtask

    task automatic drain_row(input int row, input bit gapped, input int sync_row);
        req_ack(row);
        burst_words(row, 0, 79, gapped, sync_row);
    endtask

    task automatic check_outputs_zero(input string tag);
        n_cmp++;
        if (wr_req !== 1'b0 || wr_row !== '0 || wr_data !== '0 ||
            row_done !== 1'b0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: req=%b row=%0d data=%h done=%b ovf=%b want all 0",
                     tag, wr_req, wr_row, wr_data, row_done, overflow);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        do_reset();
        check_outputs_zero("reset_state");
    endtask

    task automatic test_single_row();
        logic [127:0] w0_exp;
        logic [127:0] w79_exp;
        w0_exp  = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
        w79_exp = 128'h027F_027E_027D_027C_027B_027A_0279_0278;
        send_pixels(0, 0, 640, 1'b0);
        req_ack(0);
        burst_words(0, 0, 0, 1'b0, -1);
        n_cmp++;
        if (wr_data !== w0_exp) begin
            n_bad++;
            $display("FAIL word0_const: wr_data=%h want %h", wr_data, w0_exp);
        end
        burst_words(0, 1, 78, 1'b0, -1);
        burst_words(0, 79, 79, 1'b0, -1);
        n_cmp++;
        if (wr_data !== w79_exp) begin
            n_bad++;
            $display("FAIL word79_const: wr_data=%h want %h", wr_data, w79_exp);
        end
        tick();
        n_cmp++;
        if (wr_req !== 1'b0 || row_done !== 1'b0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL after_row0: req=%b done=%b ovf=%b want 0/0/0", wr_req, row_done, overflow);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send_pixels(0, 0, 640, 1'b1);
        send_pixels(1, 0, 640, 1'b1);
        n_cmp++;
        if (wr_req !== 1'b1 || wr_row !== 9'd0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL both_full: req=%b row=%0d ovf=%b want 1/0/0", wr_req, wr_row, overflow);
        end
        send_pixels(2, 0, 640, 1'b1);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow_set: overflow=%b want 1", overflow);
        end
        drain_row(0, 1'b0, -1);
        drain_row(1, 1'b0, -1);
        repeat (20) tick();
        n_cmp++;
        if (wr_req !== 1'b0 || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL no_third_row: req=%b ovf=%b want 0/1", wr_req, overflow);
        end
    endtask

    // Continues from test_overflow: row counter is 3 and overflow is set.
    task automatic test_frame_restart();
        send_pixels(3, 0, 640, 1'b0);
        drain_row(3, 1'b0, -1);
        send_pixels(4, 0, 640, 1'b0);
        req_ack(4);
        burst_words(4, 0, 39, 1'b0, -1);
        send_pixels(5, 0, 300, 1'b0);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow_sticky: overflow=%b want 1", overflow);
        end
        frame_start = 1'b1;
        pix_valid   = 1'b1;
        pix_data    = pix_val(0, 0);
        tick();
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL overflow_clear: overflow=%b want 0", overflow);
        end
        burst_words(4, 40, 79, 1'b0, -1);
        send_pixels(0, 1, 639, 1'b0);
        drain_row(0, 1'b0, -1);
    endtask

    task automatic test_simultaneous_free();
        do_reset();
        send_pixels(0, 0, 640, 1'b0);
        send_pixels(1, 0, 640, 1'b0);
        drain_row(0, 1'b0, 2);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL free_collide: overflow=%b want 0", overflow);
        end
        send_pixels(2, 1, 639, 1'b0);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL free_row2: overflow=%b want 0", overflow);
        end
        drain_row(1, 1'b0, -1);
    endtask

    // Continues from test_simultaneous_free: row 2 sits in bank 0.
    task automatic test_gapped_drain();
        tick();
        wr_data_en = 1'b1;
        tick();
        wr_data_en = 1'b0;
        n_cmp++;
        if (wr_req !== 1'b1 || wr_data !== row_word(1, 79)) begin
            n_bad++;
            $display("FAIL en_outside_burst: req=%b data=%h want 1 / %h",
                     wr_req, wr_data, row_word(1, 79));
        end
        drain_row(2, 1'b1, -1);
    endtask

    task automatic test_row_wrap_and_reset();
        do_reset();
        for (int r = 0; r <= TB_ROWS; r++) begin
            send_pixels(r % TB_ROWS, 0, 640, 1'b0);
            drain_row(r % TB_ROWS, 1'b0, -1);
        end
        send_pixels(1, 0, 640, 1'b0);
        req_ack(1);
        burst_words(1, 0, 39, 1'b0, -1);
        rst_n      = 1'b0;
        wr_data_en = 1'b1;
        tick();
        wr_data_en = 1'b0;
        check_outputs_zero("reset_mid_burst");
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_overflow();
        test_frame_restart();
        test_simultaneous_free();
        test_gapped_drain();
        test_row_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
